// File: rtl/uart_pkg.sv
// Shared UART constants and the baud divisor helper used by the tick generators.
package uart_pkg;

    localparam int unsigned BAUD_CLK_HZ  = 12_000_000;
    localparam int unsigned DEFAULT_BAUD = 115_200;

    // Divisor rounded to nearest: 12 MHz / 115200 -> 104.
    function automatic int unsigned calc_counter_val(input int unsigned clk_hz,
                                                     input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int unsigned DEFAULT_COUNTER_VAL = calc_counter_val(BAUD_CLK_HZ, DEFAULT_BAUD);

endpackage

// File: rtl/clk_baud_pulse_gen.sv
// Baud tick generator: divides clk_in by COUNTER_VAL and emits a registered one-cycle pulse
// when the phase counter equals PULSE_DELAY. Dropping enable restarts the phase.
module clk_baud_pulse_gen
    import uart_pkg::*;
#(
    parameter int unsigned COUNTER_VAL = DEFAULT_COUNTER_VAL,
    parameter int unsigned PULSE_DELAY = 0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic enable,
    output logic clk_pulse
);

    localparam int unsigned CntW = (COUNTER_VAL <= 2) ? 1 : $clog2(COUNTER_VAL);
    localparam logic [CntW-1:0] MaxCnt   = CntW'(COUNTER_VAL - 1);
    localparam logic [CntW-1:0] PulseCnt = CntW'(PULSE_DELAY);

    if (COUNTER_VAL < 2) begin : g_bad_counter_val
        $error("clk_baud_pulse_gen: COUNTER_VAL must be >= 2");
    end
    if (PULSE_DELAY >= COUNTER_VAL) begin : g_bad_pulse_delay
        $error("clk_baud_pulse_gen: PULSE_DELAY must be < COUNTER_VAL");
    end

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            pulse_d, pulse_q;

    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (enable) begin
            cnt_d   = (cnt_q == MaxCnt) ? '0 : cnt_q + 1'b1;
            pulse_d = (cnt_q == PulseCnt);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign clk_pulse = pulse_q;

endmodule

// File: tb/tb_clk_baud_pulse_gen.sv
// Directed bench for clk_baud_pulse_gen: four phase-locked instances sharing clock and enable.
module tb_clk_baud_pulse_gen;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;
    logic enable   = 1'b0;
    logic pa, pb, pc, pd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    clk_baud_pulse_gen #(.COUNTER_VAL(104), .PULSE_DELAY(0)) u_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable(enable), .clk_pulse(pa));
    clk_baud_pulse_gen #(.COUNTER_VAL(104), .PULSE_DELAY(52)) u_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable(enable), .clk_pulse(pb));
    clk_baud_pulse_gen #(.COUNTER_VAL(2), .PULSE_DELAY(1)) u_c (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable(enable), .clk_pulse(pc));
    clk_baud_pulse_gen #(.COUNTER_VAL(104), .PULSE_DELAY(103)) u_d (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable(enable), .clk_pulse(pd));

    // Expected {d,c,b,a} when sampled after edge E0+j: high iff j mod period == delay.
    function automatic logic [3:0] model(input int j);
        logic [3:0] m;
        m[0] = ((j % 104) == 0);
        m[1] = ((j % 104) == 52);
        m[2] = ((j % 2) == 1);
        m[3] = ((j % 104) == 103);
        return m;
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        #1 rst_n_in = 1'b0;
        #1;
        obs = {pd, pc, pb, pa};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async got %b expected 0000", obs);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got %b expected 0000", i, obs);
            end
        end
        rst_n_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_disabled cyc=%0d got %b expected 0000", i, obs);
            end
        end
    endtask

    task automatic test_startup_phase();
        logic [3:0] obs;
        enable = 1'b1;
        for (int j = 0; j < 260; j++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== model(j)) begin
                n_fail++;
                $display("FAIL startup_phase j=%0d got %b expected %b", j, obs, model(j));
            end
        end
    endtask

    task automatic test_free_run();
        logic [3:0] obs;
        int ca, cb, cc, cd;
        ca = 0; cb = 0; cc = 0; cd = 0;
        enable = 1'b0;
        @(negedge clk_in);
        obs = {pd, pc, pb, pa};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL free_run_clear got %b expected 0000", obs);
        end
        enable = 1'b1;
        for (int j = 0; j < 500; j++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            ca += int'(obs[0]);
            cb += int'(obs[1]);
            cc += int'(obs[2]);
            cd += int'(obs[3]);
            n_checks++;
            if (obs !== model(j)) begin
                n_fail++;
                $display("FAIL free_run j=%0d got %b expected %b", j, obs, model(j));
            end
        end
        n_checks++;
        if (ca !== 5) begin
            n_fail++;
            $display("FAIL free_run_count_a got %0d expected 5", ca);
        end
        n_checks++;
        if (cb !== 5) begin
            n_fail++;
            $display("FAIL free_run_count_b got %0d expected 5", cb);
        end
        n_checks++;
        if (cc !== 250) begin
            n_fail++;
            $display("FAIL free_run_count_c got %0d expected 250", cc);
        end
        n_checks++;
        if (cd !== 4) begin
            n_fail++;
            $display("FAIL free_run_count_d got %0d expected 4", cd);
        end
    endtask

    task automatic test_enable_gap();
        logic [3:0] obs;
        enable = 1'b0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL enable_gap cyc=%0d got %b expected 0000", g, obs);
            end
        end
        enable = 1'b1;
        for (int j = 0; j < 120; j++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== model(j)) begin
                n_fail++;
                $display("FAIL gap_restart j=%0d got %b expected %b", j, obs, model(j));
            end
        end
    endtask

    // Drops enable for exactly the edge that would have produced A's pulse.
    task automatic test_single_drop();
        logic [3:0] obs;
        for (int j = 120; j < 208; j++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== model(j)) begin
                n_fail++;
                $display("FAIL pre_drop j=%0d got %b expected %b", j, obs, model(j));
            end
        end
        enable = 1'b0;
        @(negedge clk_in);
        obs = {pd, pc, pb, pa};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_drop_lost got %b expected 0000", obs);
        end
        enable = 1'b1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== model(j)) begin
                n_fail++;
                $display("FAIL drop_restart j=%0d got %b expected %b", j, obs, model(j));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] obs;
        for (int j = 60; j <= 104; j++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== model(j)) begin
                n_fail++;
                $display("FAIL pre_reset j=%0d got %b expected %b", j, obs, model(j));
            end
        end
        // A is high here; reset lands between edges.
        #2 rst_n_in = 1'b0;
        #1;
        obs = {pd, pc, pb, pa};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_drop got %b expected 0000", obs);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL async_reset_hold cyc=%0d got %b expected 0000", i, obs);
            end
        end
        rst_n_in = 1'b1;
        for (int j = 0; j < 110; j++) begin
            @(negedge clk_in);
            obs = {pd, pc, pb, pa};
            n_checks++;
            if (obs !== model(j)) begin
                n_fail++;
                $display("FAIL post_reset j=%0d got %b expected %b", j, obs, model(j));
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup_phase();
        test_free_run();
        test_enable_gap();
        test_single_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
